heq_scale_divider: RTL and testbench

//  Histogram-equalisation output mapper. Computes g = ((cdf_in-cdf_min)*(2^LPOW-1)) / (NUM_PIX-cdf_min)
//  per grey level with a parametrised iterative restoring divider (1 quotient bit/clk).

---
 rtl/heq_pkg.sv | 26 ++
 rtl/heq_div_core.sv | 69 ++++++
 rtl/heq_scale_divider.sv | 122 ++++++++++++
 tb/tb_heq_scale_divider.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/heq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | heq_pkg : shared state encoding, width helpers and defaults for the      |
// |           histogram-equalisation scale divider. Rev 1.0                  |
// +--------------------------------------------------------------------------+
package heq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } heq_state_t;

  localparam int DEF_NUM_PIX = 307200;

  function automatic int num_w(input int cdf_w, input int lpow);
    return cdf_w + lpow;
  endfunction

  function automatic int level_max(input int lpow);
    return (1 << lpow) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/heq_div_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | heq_div_core : restoring divider, one quotient bit per clock.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module heq_div_core #(
  parameter int NUM_W = 40,
  parameter int DEN_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] dividend,
  input  logic [DEN_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient,
  output logic [DEN_W-1:0] remainder
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] r_num;
  logic [NUM_W-1:0] r_quo;
  logic [DEN_W-1:0] r_rem;
  logic [DEN_W-1:0] r_den;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [DEN_W:0]   w_trial;
  logic [DEN_W:0]   w_diff;
  logic             w_fit;

  assign w_trial = {r_rem, r_num[NUM_W-1]};
  assign w_fit   = (w_trial >= {1'b0, r_den});
  assign w_diff  = w_trial - {1'b0, r_den};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_num  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_den  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_num  <= dividend;
      r_den  <= divisor;
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= CNT_W'(NUM_W);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_num <= r_num << 1;
      r_quo <= {r_quo[NUM_W-2:0], w_fit};
      r_rem <= w_fit ? w_diff[DEN_W-1:0] : w_trial[DEN_W-1:0];
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
    end
  end

  // done flags the final step so the caller can move on in lock-step with it
  assign done      = r_busy && (r_cnt == CNT_W'(1));
  assign busy      = r_busy;
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/heq_scale_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | heq_scale_divider : maps a CDF value to an equalised grey level with     |
// | handshakes, optional rounding, saturation and divide-by-zero flag. Rev 1.0|
// +--------------------------------------------------------------------------+
module heq_scale_divider
  import heq_pkg::*;
#(
  parameter int CDF_W   = 32,
  parameter int LPOW    = 8,
  parameter int NUM_PIX = DEF_NUM_PIX,
  parameter int ROUND   = 0,
  parameter int TAG_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CDF_W-1:0] cdf_in,
  input  logic [CDF_W-1:0] cdf_min,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LPOW-1:0]  g_out,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_err
);

  localparam int               NUM_W     = num_w(CDF_W, LPOW);
  localparam logic [CDF_W-1:0] PIX       = CDF_W'(NUM_PIX);
  localparam logic [NUM_W:0]   LMAX_EXT  = (NUM_W+1)'(level_max(LPOW));

  heq_state_t       r_state;
  logic [NUM_W-1:0] r_num;
  logic [CDF_W-1:0] r_den;
  logic [TAG_W-1:0] r_tag;

  logic [CDF_W-1:0] w_d;
  logic [NUM_W-1:0] w_num;
  logic [CDF_W-1:0] w_den;
  logic             w_start;
  logic             w_core_busy;
  logic             w_core_done;
  logic [NUM_W-1:0] w_quo;
  logic [CDF_W-1:0] w_rem;
  logic             w_up;
  logic [NUM_W:0]   w_qr;
  logic [LPOW-1:0]  w_sat;

  // numerator = d * (2^LPOW - 1), formed at full width so nothing is lost
  assign w_d   = (cdf_in >= cdf_min) ? (cdf_in - cdf_min) : '0;
  assign w_num = {w_d, {LPOW{1'b0}}} - NUM_W'(w_d);
  assign w_den = (cdf_min >= PIX) ? '0 : (PIX - cdf_min);

  assign w_start = (r_state == LOAD) && (r_den != '0);

  heq_div_core #(
    .NUM_W (NUM_W),
    .DEN_W (CDF_W)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (w_start),
    .dividend  (r_num),
    .divisor   (r_den),
    .busy      (w_core_busy),
    .done      (w_core_done),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  assign w_up  = (ROUND != 0) && ({w_rem, 1'b0} >= {1'b0, r_den});
  assign w_qr  = {1'b0, w_quo} + (NUM_W+1)'(w_up);
  assign w_sat = (w_qr > LMAX_EXT) ? LMAX_EXT[LPOW-1:0] : w_qr[LPOW-1:0];

  assign in_ready = (r_state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_num     <= '0;
      r_den     <= '0;
      r_tag     <= '0;
      out_valid <= 1'b0;
      g_out     <= '0;
      out_tag   <= '0;
      div_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_num   <= w_num;
            r_den   <= w_den;
            r_tag   <= in_tag;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          div_err <= (r_den == '0);
          r_state <= (r_den == '0) ? DONE : ITER;
        end
        ITER: begin
          if (w_core_done || !w_core_busy) r_state <= DONE;
        end
        DONE: begin
          // first DONE cycle registers the result; afterwards hold until taken
          if (!out_valid) begin
            g_out     <= div_err ? '0 : w_sat;
            out_tag   <= r_tag;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_heq_scale_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_heq_scale_divider : directed self-checking bench, truncating and      |
// | rounding instances driven in parallel. Rev 1.0                           |
// +--------------------------------------------------------------------------+
module tb_heq_scale_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] cdf_in = '0;
  logic [31:0] cdf_min = '0;
  logic [7:0]  in_tag = '0;

  logic       in_ready0, out_valid0, div_err0;
  logic [7:0] g0, tag0;
  logic       in_ready1, out_valid1, div_err1;
  logic [7:0] g1, tag1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  heq_scale_divider #(.ROUND(0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .cdf_in(cdf_in), .cdf_min(cdf_min), .in_tag(in_tag),
    .out_valid(out_valid0), .out_ready(out_ready), .g_out(g0),
    .out_tag(tag0), .div_err(div_err0)
  );

  heq_scale_divider #(.ROUND(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .cdf_in(cdf_in), .cdf_min(cdf_min), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready), .g_out(g1),
    .out_tag(tag1), .div_err(div_err1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid0 || lat >= 200) break;
    end
  endtask

  task automatic run(input string nm, input logic [31:0] ci, input logic [31:0] cm,
                     input logic [7:0] t, input int elat, input logic [7:0] eg0,
                     input logic [7:0] eg1, input logic eerr);
    int lat;
    @(negedge clk);
    cdf_in = ci; cdf_min = cm; in_tag = t; in_valid = 1'b1;
    check({nm, "_in_ready"}, 64'(in_ready0), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cdf_in = 32'hFFFF_FFFF; cdf_min = 32'd7; in_tag = 8'hAA;
    wait_out(lat);
    check({nm, "_latency"}, 64'(lat), 64'(elat));
    check({nm, "_valid1"}, 64'(out_valid1), 64'd1);
    check({nm, "_g_trunc"}, 64'(g0), 64'(eg0));
    check({nm, "_g_round"}, 64'(g1), 64'(eg1));
    check({nm, "_tag"}, 64'(tag0), 64'(t));
    check({nm, "_div_err"}, 64'(div_err0), 64'(eerr));
    @(posedge clk);
    #1;
    check({nm, "_valid_drop"}, 64'(out_valid0), 64'd0);
    check({nm, "_ready_back"}, 64'(in_ready0), 64'd1);
  endtask

  initial begin
    int lat;
    logic stable;
    logic seen;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready0), 64'd1);
    check("rst_out_valid", 64'(out_valid0), 64'd0);
    check("rst_g_out", 64'(g0), 64'd0);
    check("rst_out_tag", 64'(tag0), 64'd0);
    check("rst_div_err", 64'(div_err0), 64'd0);
    reset = 1'b0;

    run("full",  32'd307200, 32'd0,      8'h01, 42, 8'd255, 8'd255, 1'b0);
    run("half",  32'd153650, 32'd100,    8'h02, 42, 8'd127, 8'd128, 1'b0);
    run("den0",  32'd307200, 32'd307200, 8'h04, 2,  8'd0,   8'd0,   1'b1);
    run("clamp", 32'd50,     32'd100,    8'h03, 42, 8'd0,   8'd0,   1'b0);
    run("sat",   32'd614400, 32'd0,      8'h07, 42, 8'd255, 8'd255, 1'b0);
    run("small", 32'd2000,   32'd1000,   8'h08, 42, 8'd0,   8'd1,   1'b0);
    run("mid",   32'd100000, 32'd0,      8'h0A, 42, 8'd83,  8'd83,  1'b0);

    // back-pressure: result held, second request waits for the handshake
    out_ready = 1'b0;
    @(negedge clk);
    cdf_in = 32'd307200; cdf_min = 32'd0; in_tag = 8'h05; in_valid = 1'b1;
    @(posedge clk);
    #1;
    cdf_in = 32'd100000; cdf_min = 32'd0; in_tag = 8'h06;
    wait_out(lat);
    check("bp_latency", 64'(lat), 64'd42);
    check("bp_g_first", 64'(g0), 64'd255);
    check("bp_tag_first", 64'(tag0), 64'h05);
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (g0 !== 8'd255 || tag0 !== 8'h05 || out_valid0 !== 1'b1 || in_ready0 !== 1'b0)
        stable = 1'b0;
    end
    check("bp_hold_stable", 64'(stable), 64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_drop", 64'(out_valid0), 64'd0);
    check("bp_idle_ready", 64'(in_ready0), 64'd1);
    @(posedge clk);
    #1;
    check("bp_second_accepted", 64'(in_ready0), 64'd0);
    in_valid = 1'b0;
    wait_out(lat);
    check("bp2_latency", 64'(lat), 64'd42);
    check("bp_g_second", 64'(g0), 64'd83);
    check("bp_tag_second", 64'(tag0), 64'h06);
    @(posedge clk);
    #1;
    check("bp2_valid_drop", 64'(out_valid0), 64'd0);

    // asynchronous reset in the middle of an iteration
    @(negedge clk);
    cdf_in = 32'd307200; cdf_min = 32'd100; in_tag = 8'h09; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_in_ready", 64'(in_ready0), 64'd1);
    check("arst_out_valid", 64'(out_valid0), 64'd0);
    check("arst_g_out", 64'(g0), 64'd0);
    check("arst_out_tag", 64'(tag0), 64'd0);
    check("arst_div_err", 64'(div_err0), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (out_valid0 !== 1'b0) seen = 1'b1;
    end
    check("arst_no_result", 64'(seen), 64'd0);

    run("post_rst", 32'd307200, 32'd0, 8'h11, 42, 8'd255, 8'd255, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
